// File: rtl/stride_counter_if.sv
// stride_counter_if: bundle of the control and status signals of a stride_counter.
//   master modport : loop sequencer side (drives start/en/down/cont/limit/step,
//                    observes count/count_rev/wrap/busy/done)
//   slave modport  : the stride_counter itself
// Parameter N must match the N of the attached stride_counter.
interface stride_counter_if #(
  parameter int N = 4
);
  logic         start;
  logic         en;
  logic         down;
  logic         cont;
  logic [N-1:0] limit;
  logic [N-1:0] step;
  logic [N-1:0] count;
  logic [N-1:0] count_rev;
  logic         wrap;
  logic         busy;
  logic         done;

  modport master (
    output start, en, down, cont, limit, step,
    input  count, count_rev, wrap, busy, done
  );

  modport slave (
    input  start, en, down, cont, limit, step,
    output count, count_rev, wrap, busy, done
  );
endinterface

// File: rtl/stride_counter.sv
// stride_counter: loadable modulo counter (range 0..limit) with programmable
// stride and direction and a start/busy/done run controller. Generates NTT
// loop indices; instances chain through wrap to build nested loops.
// All state changes on the falling edge of clk; rst is asynchronous, active-high.
//
// Ports:
//   clk, rst        : clock (falling-edge active) and async active-high reset
//   bus (slave)     : start, en, down, cont, limit, step in;
//                     count, count_rev, wrap, busy, done out
//
// Build option: define STRIDE_COUNTER_BITREV_EN to drive count_rev with the
// bit-reversed count; otherwise count_rev is tied to zero.
module stride_counter #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  stride_counter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r, state_s;
  logic [N-1:0] count_r, count_s;
  logic         wrap_r, wrap_s;
  logic         busy_r, done_r;
  logic         down_r, down_s;
  logic         cont_r, cont_s;
  logic [N-1:0] limit_r, limit_s;
  logic [N-1:0] step_r, step_s;

  // Arithmetic is carried in N+1 bits so count+step and limit+1 never overflow.
  logic [N:0]   sum_up_s;
  logic [N:0]   span_s;
  logic         term_up_s;
  logic         term_dn_s;
  logic [N:0]   next_up_s;
  logic [N:0]   next_dn_s;

  // Candidate next values for one advance in either direction.
  always_comb begin
    span_s    = {1'b0, limit_r} + {{N{1'b0}}, 1'b1};
    sum_up_s  = {1'b0, count_r} + {1'b0, step_r};
    term_up_s = (sum_up_s > {1'b0, limit_r});
    term_dn_s = (count_r < step_r);
    if (term_up_s) begin
      next_up_s = sum_up_s - span_s;
    end else begin
      next_up_s = sum_up_s;
    end
    if (term_dn_s) begin
      next_dn_s = {1'b0, count_r} + span_s - {1'b0, step_r};
    end else begin
      next_dn_s = {1'b0, count_r} - {1'b0, step_r};
    end
  end

  // Next-state and next-register logic; restart has priority over advancing.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    wrap_s  = 1'b0;
    down_s  = down_r;
    cont_s  = cont_r;
    limit_s = limit_r;
    step_s  = step_r;
    if (bus.start) begin
      down_s  = bus.down;
      cont_s  = bus.cont;
      limit_s = bus.limit;
      // A zero stride would never terminate; treat it as unit stride.
      if (bus.step == {N{1'b0}}) begin
        step_s = N'(1'b1);
      end else begin
        step_s = bus.step;
      end
      if (bus.down) begin
        count_s = bus.limit;
      end else begin
        count_s = {N{1'b0}};
      end
      state_s = RUN;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RUN: begin
          if (bus.en) begin
            if (down_r) begin
              count_s = next_dn_s[N-1:0];
              wrap_s  = term_dn_s;
            end else begin
              count_s = next_up_s[N-1:0];
              wrap_s  = term_up_s;
            end
            if (wrap_s && !cont_r) begin
              state_s = DONE;
            end else begin
              state_s = RUN;
            end
          end else begin
            state_s = RUN;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, falling-edge clocked with async reset.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= {N{1'b0}};
      wrap_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      down_r  <= 1'b0;
      cont_r  <= 1'b0;
      limit_r <= {N{1'b0}};
      step_r  <= {N{1'b0}};
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      wrap_r  <= wrap_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      down_r  <= down_s;
      cont_r  <= cont_s;
      limit_r <= limit_s;
      step_r  <= step_s;
    end
  end

  assign bus.count = count_r;
  assign bus.wrap  = wrap_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

`ifdef STRIDE_COUNTER_BITREV_EN
  function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = v[N-1-i];
    end
    return r;
  endfunction

  assign bus.count_rev = bitrev(count_r);
`else
  assign bus.count_rev = {N{1'b0}};
`endif

endmodule

// File: tb/tb_stride_counter.sv
module tb_stride_counter;

  localparam int N = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  stride_counter_if #(.N(N)) bus ();

  stride_counter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Wait for the next active (falling) edge, then settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input logic d, input logic c, input logic [N-1:0] lim,
                        input logic [N-1:0] stp);
    bus.down  = d;
    bus.cont  = c;
    bus.limit = lim;
    bus.step  = stp;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.wrap !== 1'b0 ||
        bus.done !== 1'b0 || bus.count_rev !== 4'd0) begin
      bad++;
      $display("FAIL reset_init: count=%0d busy=%b wrap=%b done=%b rev=%0d want 0/0/0/0/0",
               bus.count, bus.busy, bus.wrap, bus.done, bus.count_rev);
    end
    tick();
    rst = 1'b0;
    tick();
    launch(1'b0, 1'b1, 4'd9, 4'd1);
    tick();
    tick();
    tick();
    // count is 3 here; reset between edges must act immediately.
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_midrun: count=%0d busy=%b wrap=%b want 0/0/0",
               bus.count, bus.busy, bus.wrap);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.count !== 4'd0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b count=%0d want 0/0", bus.busy, bus.count);
    end
  endtask

  task automatic test_oneshot_up();
    launch(1'b0, 1'b0, 4'd9, 4'd1);
    total++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_start: count=%0d busy=%b want 0/1", bus.count, bus.busy);
    end
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++;
      if (bus.count !== 4'(i) || bus.wrap !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL oneshot_adv%0d: count=%0d wrap=%b busy=%b done=%b want %0d/0/1/0",
                 i, bus.count, bus.wrap, bus.busy, bus.done, i);
      end
    end
    tick();
    total++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_term: count=%0d wrap=%b done=%b busy=%b want 0/1/1/0",
               bus.count, bus.wrap, bus.done, bus.busy);
    end
    tick();
    total++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_idle: count=%0d wrap=%b done=%b busy=%b want 0/0/0/0",
               bus.count, bus.wrap, bus.done, bus.busy);
    end
  endtask

  task automatic test_free_stride();
    logic [N-1:0] exp_c [8] = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd2, 4'd5, 4'd8, 4'd1};
    logic         exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    launch(1'b0, 1'b1, 4'd9, 4'd3);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      total++;
      if (bus.count !== exp_c[i] || bus.wrap !== exp_w[i] || bus.busy !== 1'b1 ||
          bus.done !== 1'b0) begin
        bad++;
        $display("FAIL free_stride%0d: count=%0d wrap=%b busy=%b done=%b want %0d/%b/1/0",
                 i, bus.count, bus.wrap, bus.busy, bus.done, exp_c[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_down_stall();
    logic [N-1:0] exp_c [8] = '{4'd7, 4'd5, 4'd3, 4'd3, 4'd3, 4'd3, 4'd1, 4'd7};
    logic         exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         en_v  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    launch(1'b1, 1'b1, 4'd7, 4'd2);
    // Garbage on latched inputs must be ignored during the run.
    bus.down  = 1'b0;
    bus.limit = 4'd15;
    bus.step  = 4'd5;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      total++;
      if (bus.count !== exp_c[i] || bus.wrap !== exp_w[i] || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL down_stall%0d: count=%0d wrap=%b busy=%b want %0d/%b/1",
                 i, bus.count, bus.wrap, bus.busy, exp_c[i], exp_w[i]);
      end
      bus.en = en_v[i];
    end
    bus.en = 1'b1;
  endtask

  task automatic test_restart();
    launch(1'b0, 1'b1, 4'd9, 4'd3);
    tick();
    tick();
    total++;
    if (bus.count !== 4'd6) begin
      bad++;
      $display("FAIL restart_pre: count=%0d want 6", bus.count);
    end
    launch(1'b0, 1'b1, 4'd4, 4'd1);
    total++;
    if (bus.count !== 4'd0 || bus.wrap !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_load: count=%0d wrap=%b busy=%b want 0/0/1",
               bus.count, bus.wrap, bus.busy);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++;
      if (bus.count !== 4'(i % 5) || bus.wrap !== (i == 5)) begin
        bad++;
        $display("FAIL restart_adv%0d: count=%0d wrap=%b want %0d/%b",
                 i, bus.count, bus.wrap, i % 5, (i == 5));
      end
    end
  endtask

  task automatic test_boundaries();
    // Zero stride behaves as unit stride.
    launch(1'b0, 1'b1, 4'd3, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (bus.count !== 4'(i % 4) || bus.wrap !== (i == 4)) begin
        bad++;
        $display("FAIL step0_adv%0d: count=%0d wrap=%b want %0d/%b",
                 i, bus.count, bus.wrap, i % 4, (i == 4));
      end
    end
    // Zero limit: every advance is terminal and count stays 0.
    launch(1'b1, 1'b1, 4'd0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.count !== 4'd0 || bus.wrap !== 1'b1 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL limit0_adv%0d: count=%0d wrap=%b busy=%b want 0/1/1",
                 i, bus.count, bus.wrap, bus.busy);
      end
    end
    // One-shot down, then restart while in DONE.
    launch(1'b1, 1'b0, 4'd1, 4'd1);
    tick();
    tick();
    total++;
    if (bus.count !== 4'd1 || bus.wrap !== 1'b1 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL down_oneshot: count=%0d wrap=%b done=%b want 1/1/1",
               bus.count, bus.wrap, bus.done);
    end
    launch(1'b0, 1'b0, 4'd5, 4'd2);
    total++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL restart_in_done: count=%0d busy=%b done=%b wrap=%b want 0/1/0/0",
               bus.count, bus.busy, bus.done, bus.wrap);
    end
  endtask

  task automatic test_bitrev();
    logic [N-1:0] want;
    launch(1'b0, 1'b1, 4'd15, 4'd1);
    for (int i = 1; i <= 6; i++) begin
      tick();
`ifdef STRIDE_COUNTER_BITREV_EN
      if (i == 1) want = 4'b1000;
      else if (i == 6) want = 4'b0110;
      else want = {bus.count[0], bus.count[1], bus.count[2], bus.count[3]};
`else
      want = 4'd0;
`endif
      total++;
      if (bus.count !== 4'(i) || bus.count_rev !== want) begin
        bad++;
        $display("FAIL bitrev%0d: count=%b rev=%b want %b/%b",
                 i, bus.count, bus.count_rev, 4'(i), want);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.en    = 1'b1;
    bus.down  = 1'b0;
    bus.cont  = 1'b0;
    bus.limit = 4'd0;
    bus.step  = 4'd0;
    #1;
    test_reset();
    test_oneshot_up();
    test_free_stride();
    test_down_stall();
    test_restart();
    test_boundaries();
    test_bitrev();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stride_counter.md
# stride_counter

Parametrised, loadable modulo counter with programmable limit, stride and direction, plus a start/busy/done run controller. It generates the loop indices for the NTT address generators: butterfly index, group index and twiddle index. Several instances chain through `wrap` to form nested loops. It supersedes the plain free-running up/down counter wherever a bound other than 2^N, a stride, or a run-completion signal is needed.

## Interface
- `N`, 4: counter, limit and stride width in bits (N ≥ 1).
- `clk`  in  1  clock; all state updates on the falling edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin (or restart) a run; sampled on the falling edge.
- `en`  in  1  advance enable while running; 0 stalls the count.
- `down`  in  1  direction: 0 up, 1 down; latched at start.
- `cont`  in  1  1 = free-running (wrap and continue); 0 = one-shot; latched at start.
- `limit`  in  N  highest count value; range is 0..limit; latched at start.
- `step`  in  N  stride per advance; latched at start.
- `count`  out  N  current index (registered).
- `count_rev`  out  N  bit-reversed `count` (see Configuration).
- `wrap`  out  1  one-cycle pulse: the last advance wrapped.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse: the one-shot run completed.

## Operation
- **States:** IDLE, RUN, DONE.
  - `busy` = 1 only in RUN.
  - `done` = 1 only in DONE.
- **IDLE:** `count` holds. `start` = 1 → RUN.
- **Start:** `start` = 1 latches `down`, `cont`, `limit` and `step`. It loads `count` with the start value:
  - up: 0
  - down: latched `limit`
- **Latched fields:** input changes during RUN are ignored.
- **Step rules:**
  - `step` = 0 is latched as 1.
  - `step` > `limit` + 1 is illegal; outputs are unspecified.
- **RUN, en = 1, one advance per edge.** Arithmetic is done in N+1 bits, no overflow.
  - Up, non-terminal: `count` + `step` ≤ `limit` → `count` + `step`.
  - Up, terminal: otherwise → `count` + `step` − (`limit` + 1).
  - Down, non-terminal: `count` ≥ `step` → `count` − `step`.
  - Down, terminal: otherwise → `count` + (`limit` + 1) − `step`.
- **Terminal advance:** sets `wrap` = 1 for the next cycle.
  - `cont` = 1: stays in RUN.
  - `cont` = 0: moves to DONE.
- **RUN, en = 0:** `count` holds; `wrap` = 0.
- **DONE:** lasts one cycle, then IDLE. `count` holds the wrapped value.
- **`start` in RUN or DONE:** restart takes priority over the advance. Relatch, reload the start value, next state RUN, `wrap` = 0.
- **`start` while in DONE:** `done` stays high for that cycle.
- **`limit` = 0:** every advance is terminal; `count` stays 0; `wrap` pulses on every advance.
- **Reset:** takes effect immediately, including mid-run.
  - State IDLE.
  - `count` = 0, `wrap` = 0, `busy` = 0, `done` = 0, `count_rev` = 0.
  - Latched fields 0, direction up.

## Timing
- `count`, `wrap`, `busy` and `done` are registered and change only on the falling edge of `clk` or on `rst`.
- **Start latency:** `start` sampled at falling edge k → `busy` = 1 and `count` = start value after edge k.
- **First advance:** occurs at edge k+1 if `en` = 1.
- **Advance latency:** one per enabled edge, one cycle each.
- **`wrap`:** asserted in the same cycle as the wrapped `count`, for exactly one cycle per terminal advance.
- **One-shot run:** for `step` = 1, completes `limit` + 1 advances after the start edge. `done` is high in the cycle after the terminal edge.
- **`count_rev`:** combinational from `count`, no extra latency.

## Configuration
- **`STRIDE_COUNTER_BITREV_EN` defined:** `count_rev[i]` = `count[N-1-i]`, used for bit-reversed NTT addressing.
- **Not defined:** `count_rev` is tied to 0 and no reversal logic is built.
- The port list is identical in both builds.

## Test plan
- **Reset:** N = 4, assert `rst` asynchronously mid-RUN (between edges) → `count` = 0, `busy` = 0, `wrap` = 0 immediately.
- **One-shot up:** `limit` = 9, `step` = 1, `cont` = 0, `en` = 1 → `count` 0..9. The 10th advance gives `count` = 0 with `wrap` = 1, then `done` = 1 for one cycle, then IDLE with `busy` = 0.
- **Free-running strided up:** `limit` = 9, `step` = 3, `cont` = 1 → 0, 3, 6, 9, 2 (`wrap` = 1), 5, 8, 1 (`wrap` = 1); `busy` stays 1.
- **Down with stall:** `down` = 1, `limit` = 7, `step` = 2 → 7, 5, 3, 1, 7 (`wrap` = 1). With `en` = 0 for 3 cycles at `count` = 3, `count` holds and `wrap` = 0.
- **Restart mid-run:** `start` pulsed at `count` = 6 while changing `limit` to 4 and `step` to 1 → `count` = 0 next cycle with no `wrap`. It then wraps after 0..4.
- **Macro build, `STRIDE_COUNTER_BITREV_EN` defined, N = 4:** `count` = 4'b0001 → `count_rev` = 4'b1000, and `count` = 4'b0110 → 4'b0110. Without the macro, `count_rev` = 0 throughout.
